pipelined_alu_adder: RTL

Parametrised, pipelined successor to the single-cycle ripple adder. It computes ADD, ADC, SUB or SBC on WIDTH-bit operands, with the carry chain split into STAGES registered slices. It produces N/Z/C/V flags, accepts one operation per cycle, and supports valid/ready handshaking with full backpressure. It sits between the CPU execute stage and writeback, where a 32-bit single-cycle carry chain would limit clock frequency.

---
 rtl/pipelined_alu_adder.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipelined_alu_adder.sv
// pipelined_alu_adder: ADD/ADC/SUB/SBC with the carry chain cut into STAGES registered slices,
// N/Z/C/V flags and valid/ready handshaking with whole-pipe stall on backpressure.
module pipelined_alu_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);
    localparam int S = (STAGES > 0) ? WIDTH / STAGES : 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % S) != 0 || S * STAGES != WIDTH) begin : g_bad
        $error("pipelined_alu_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic              w_adv;
    logic [WIDTH-1:0]  w_b0;
    logic              w_c0;
    logic [STAGES-1:0] w_vld;
    logic              r_cm;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_b0     = op[1] ? ~b : b;
    assign w_c0     = op[0] ? cin : op[1];

    // Stage k consumes the low slice of the remaining operand bits and appends its slice on top of the result
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_st
        localparam int R = WIDTH - k * S;
        localparam int D = (k + 1) * S;
        logic [R-1:0] w_a;
        logic [R-1:0] w_b;
        logic         w_ci;
        logic         w_v;
        logic [S:0]   w_sl;
        logic [D-1:0] w_s;
        logic         r_v;
        logic         r_c;
        logic [D-1:0] r_s;
        if (k == 0) begin : g_in
            assign w_a  = a;
            assign w_b  = w_b0;
            assign w_ci = w_c0;
            assign w_v  = in_valid;
            assign w_s  = w_sl[S-1:0];
        end else begin : g_in
            assign w_a  = g_st[k-1].g_ab.r_a;
            assign w_b  = g_st[k-1].g_ab.r_b;
            assign w_ci = g_st[k-1].r_c;
            assign w_v  = g_st[k-1].r_v;
            assign w_s  = {w_sl[S-1:0], g_st[k-1].r_s};
        end
        assign w_sl     = {1'b0, w_a[S-1:0]} + {1'b0, w_b[S-1:0]} + {{S{1'b0}}, w_ci};
        assign w_vld[k] = r_v;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_c <= w_sl[S];
                r_s <= w_s;
            end
        end
        if (k < STAGES - 1) begin : g_ab
            logic [R-S-1:0] r_a;
            logic [R-S-1:0] r_b;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[R-1:S];
                    r_b <= w_b[R-1:S];
                end
            end
        end
    end

    // Carry into the result MSB, recovered from the last slice's MSB sum bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cm <= 1'b0;
        else if (w_adv)
            r_cm <= g_st[STAGES-1].w_a[S-1] ^ g_st[STAGES-1].w_b[S-1] ^ g_st[STAGES-1].w_sl[S-1];
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign sum       = g_st[STAGES-1].r_s;
    assign flag_c    = g_st[STAGES-1].r_c;
    assign flag_v    = r_cm ^ flag_c;
    assign flag_n    = sum[WIDTH-1];
    assign flag_z    = out_valid && (sum == '0);
    assign busy      = |w_vld;
endmodule
